// File: rtl/sd_digit_history_buf_if.sv
// Bus interface for sd_digit_history_buf: digit input handshake, read port and status.
// The o_bad_digit signal exists only when SD_DIGIT_CHECK_EN is defined.
interface sd_digit_history_buf_if #(
    parameter int NUM_CH          = 2,
    parameter int DIGITS_PER_WORD = 4,
    parameter int ADDR_W          = 7,
    parameter int CNT_W           = 10
);
    logic                                i_start;
    logic                                i_digit_valid;
    logic [2*NUM_CH-1:0]                 i_digit_in;
    logic                                i_hold;
    logic                                i_done;
    logic                                o_ready;
    logic                                i_rd_en;
    logic [ADDR_W-1:0]                   i_rd_addr;
    logic [NUM_CH*DIGITS_PER_WORD-1:0]   o_rd_plus;
    logic [NUM_CH*DIGITS_PER_WORD-1:0]   o_rd_minus;
    logic                                o_rd_valid;
    logic [CNT_W-1:0]                    o_digit_cnt;
    logic [ADDR_W-1:0]                   o_wr_word;
    logic                                o_full;
    logic                                o_overflow;
`ifdef SD_DIGIT_CHECK_EN
    logic                                o_bad_digit;
`endif

    modport slave (
        input  i_start, i_digit_valid, i_digit_in, i_hold, i_done, i_rd_en, i_rd_addr,
        output o_ready, o_rd_plus, o_rd_minus, o_rd_valid, o_digit_cnt, o_wr_word,
               o_full, o_overflow
`ifdef SD_DIGIT_CHECK_EN
        , o_bad_digit
`endif
    );

    modport master (
        output i_start, i_digit_valid, i_digit_in, i_hold, i_done, i_rd_en, i_rd_addr,
        input  o_ready, o_rd_plus, o_rd_minus, o_rd_valid, o_digit_cnt, o_wr_word,
               o_full, o_overflow
`ifdef SD_DIGIT_CHECK_EN
        , o_bad_digit
`endif
    );
endinterface

// File: rtl/sd_digit_history_buf.sv
// Multi-channel signed-digit history buffer for the online divider.
// Packs one {plus,minus} digit per channel per cycle into words (first digit at the MSB),
// commits full words to RAM and serves 1-cycle reads with bypass of the word under assembly.
// Optional macro SD_DIGIT_CHECK_EN: flags and zeroes illegal digits (plus=minus=1).
module sd_digit_history_buf #(
    parameter int NUM_CH          = 2,
    parameter int DIGITS_PER_WORD = 4,
    parameter int DEPTH           = 128,
    parameter int ADDR_W          = 7,
    parameter int CNT_W           = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sd_digit_history_buf_if.slave bus
);
    localparam int DPW    = DIGITS_PER_WORD;
    localparam int VEC_W  = NUM_CH * DPW;
    localparam int POS_W  = (DPW > 1) ? $clog2(DPW) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(DPW - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_FULL} state_t;

    state_t              r_state, w_stateNext;
    logic [POS_W-1:0]    r_pos;
    logic [VEC_W-1:0]    r_asmPlus, r_asmMinus;
    logic [VEC_W-1:0]    w_asmPlusNext, w_asmMinusNext;
    logic [ADDR_W-1:0]   r_wrWord;
    logic [CNT_W-1:0]    r_digitCnt;
    logic                r_full, r_overflow;
    logic [VEC_W-1:0]    r_memPlus  [DEPTH];
    logic [VEC_W-1:0]    r_memMinus [DEPTH];
    logic [VEC_W-1:0]    r_rdPlus, r_rdMinus;
    logic                r_rdValid;
    logic [2*NUM_CH-1:0] w_cleanDigit;
    logic                w_ready, w_accept, w_wordDone, w_flushWrite, w_commit, w_lastWord;
    logic [MEM_AW-1:0]   w_rdIdx, w_wrIdx;
`ifdef SD_DIGIT_CHECK_EN
    logic                w_badDigitIn;
    logic                r_badDigit;
`endif

    assign w_ready      = (r_state == S_FILL) && !bus.i_hold && !r_full;
    assign w_accept     = w_ready && bus.i_digit_valid && !bus.i_start;
    assign w_wordDone   = w_accept && (r_pos == LAST_POS);
    assign w_flushWrite = (r_state == S_FLUSH) && !bus.i_hold && !bus.i_start && (r_pos != '0);
    assign w_commit     = w_wordDone || w_flushWrite;
    assign w_lastWord   = (r_wrWord == LAST_WORD);
    assign w_rdIdx      = bus.i_rd_addr[MEM_AW-1:0];
    assign w_wrIdx      = r_wrWord[MEM_AW-1:0];

    // Sanitise incoming digits; with checking enabled an illegal 11 digit is stored as 0
    always_comb begin
        w_cleanDigit = bus.i_digit_in;
`ifdef SD_DIGIT_CHECK_EN
        w_badDigitIn = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.i_digit_in[2*c+1] && bus.i_digit_in[2*c]) begin
                w_cleanDigit[2*c+1] = 1'b0;
                w_cleanDigit[2*c]   = 1'b0;
                w_badDigitIn        = 1'b1;
            end
        end
`endif
    end

    // Assembly word as it will look after this edge; also the bypass/write-first read value
    always_comb begin
        w_asmPlusNext  = r_asmPlus;
        w_asmMinusNext = r_asmMinus;
        if (w_accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < DPW; k++) begin
                    if (r_pos == POS_W'(k)) begin
                        w_asmPlusNext[c*DPW + DPW-1-k]  = w_cleanDigit[2*c+1];
                        w_asmMinusNext[c*DPW + DPW-1-k] = w_cleanDigit[2*c];
                    end
                end
            end
        end
    end

    // Next-state logic: start wins everything, hold freezes all transitions
    always_comb begin
        w_stateNext = r_state;
        if (bus.i_start) begin
            w_stateNext = S_FILL;
        end else if (!bus.i_hold) begin
            case (r_state)
                S_FILL: begin
                    if (w_wordDone && w_lastWord) w_stateNext = S_FULL;
                    else if (bus.i_done)          w_stateNext = S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_flushWrite && w_lastWord) w_stateNext = S_FULL;
                    else                            w_stateNext = S_FILL;
                end
                default: w_stateNext = r_state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_stateNext;
    end

    // Assembly register, position/word/digit counters and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n || bus.i_start) begin
            r_pos      <= '0;
            r_asmPlus  <= '0;
            r_asmMinus <= '0;
            r_wrWord   <= '0;
            r_digitCnt <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef SD_DIGIT_CHECK_EN
            r_badDigit <= 1'b0;
`endif
        end else begin
            if (w_commit) begin
                r_pos      <= '0;
                r_asmPlus  <= '0;
                r_asmMinus <= '0;
                r_wrWord   <= r_wrWord + ADDR_W'(1);
                if (w_lastWord) r_full <= 1'b1;
            end else if (w_accept) begin
                r_pos      <= r_pos + POS_W'(1);
                r_asmPlus  <= w_asmPlusNext;
                r_asmMinus <= w_asmMinusNext;
            end
            if (w_accept && (r_digitCnt != CNT_MAX)) r_digitCnt <= r_digitCnt + CNT_W'(1);
            if (r_full && bus.i_digit_valid) r_overflow <= 1'b1;
`ifdef SD_DIGIT_CHECK_EN
            if (w_accept && w_badDigitIn) r_badDigit <= 1'b1;
`endif
        end
    end

    // Word RAM write port; contents survive reset and start
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_memPlus[w_wrIdx]  <= w_asmPlusNext;
            r_memMinus[w_wrIdx] <= w_asmMinusNext;
        end
    end

    // Registered read port: out-of-range gives 0, the open word is bypassed from assembly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdValid <= 1'b0;
            r_rdPlus  <= '0;
            r_rdMinus <= '0;
        end else begin
            r_rdValid <= bus.i_rd_en;
            if (bus.i_rd_en) begin
                if ({1'b0, bus.i_rd_addr} >= DEPTH_EXT) begin
                    r_rdPlus  <= '0;
                    r_rdMinus <= '0;
                end else if ((bus.i_rd_addr == r_wrWord) && !r_full) begin
                    r_rdPlus  <= w_asmPlusNext;
                    r_rdMinus <= w_asmMinusNext;
                end else begin
                    r_rdPlus  <= r_memPlus[w_rdIdx];
                    r_rdMinus <= r_memMinus[w_rdIdx];
                end
            end
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_rd_plus   = r_rdPlus;
    assign bus.o_rd_minus  = r_rdMinus;
    assign bus.o_rd_valid  = r_rdValid;
    assign bus.o_digit_cnt = r_digitCnt;
    assign bus.o_wr_word   = r_wrWord;
    assign bus.o_full      = r_full;
    assign bus.o_overflow  = r_overflow;
`ifdef SD_DIGIT_CHECK_EN
    assign bus.o_bad_digit = r_badDigit;
`endif
endmodule

// File: tb/tb_sd_digit_history_buf.sv
// Testbench for sd_digit_history_buf: directed scenarios followed by randomized traffic,
// checked against a digit-list reference model; read data goes through a scoreboard queue.
module tb_sd_digit_history_buf;
    localparam int NUM_CH = 2;
    localparam int DPW    = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 6;
    localparam int VEC_W  = NUM_CH * DPW;
    localparam int DIN_W  = 2 * NUM_CH;

    typedef struct {
        bit               check;
        logic [VEC_W-1:0] plus;
        logic [VEC_W-1:0] minus;
    } rdExp_t;

    typedef enum int {M_IDLE, M_FILL, M_FLUSH, M_FULL} mState_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nCompared = 0;
    int   nMismatched = 0;
    rdExp_t expQ[$];

    mState_t          mState;
    int               mWrWord, mCnt;
    bit               mFull, mOverflow, mBad, mRdValid;
    logic [DIN_W-1:0] mCur[$];
    logic [VEC_W-1:0] mMemPlus  [DEPTH];
    logic [VEC_W-1:0] mMemMinus [DEPTH];
    bit               mMemValid [DEPTH];

    always #5 clk = ~clk;

    sd_digit_history_buf_if #(.NUM_CH(NUM_CH), .DIGITS_PER_WORD(DPW), .ADDR_W(ADDR_W),
                              .CNT_W(CNT_W)) bus ();

    sd_digit_history_buf #(.NUM_CH(NUM_CH), .DIGITS_PER_WORD(DPW), .DEPTH(DEPTH),
                           .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word value from an ordered list of digits: k-th digit at bit DPW-1-k of each channel
    function automatic void packWord(input logic [DIN_W-1:0] digs[$],
                                     output logic [VEC_W-1:0] p, output logic [VEC_W-1:0] m);
        p = '0;
        m = '0;
        foreach (digs[k]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                p[c*DPW + DPW-1-k] = digs[k][2*c+1];
                m[c*DPW + DPW-1-k] = digs[k][2*c];
            end
        end
    endfunction

    function automatic logic [DIN_W-1:0] cleanDigit(input logic [DIN_W-1:0] d, output bit bad);
        logic [DIN_W-1:0] r;
        r = d;
        bad = 1'b0;
`ifdef SD_DIGIT_CHECK_EN
        for (int c = 0; c < NUM_CH; c++) begin
            if (d[2*c+1] && d[2*c]) begin
                r[2*c+1] = 1'b0;
                r[2*c]   = 1'b0;
                bad      = 1'b1;
            end
        end
`endif
        return r;
    endfunction

    function automatic void modelCommit();
        logic [VEC_W-1:0] p, m;
        packWord(mCur, p, m);
        mMemPlus[mWrWord]  = p;
        mMemMinus[mWrWord] = m;
        mMemValid[mWrWord] = 1'b1;
        mCur.delete();
        mWrWord++;
        if (mWrWord == DEPTH) begin
            mFull  = 1'b1;
            mState = M_FULL;
        end
    endfunction

    task automatic checkOutput();
        compare("digit_cnt", 32'(bus.o_digit_cnt), 32'(mCnt));
        compare("wr_word", 32'(bus.o_wr_word), 32'(mWrWord));
        compare("full", 32'(bus.o_full), 32'(mFull));
        compare("overflow", 32'(bus.o_overflow), 32'(mOverflow));
        compare("rd_valid", 32'(bus.o_rd_valid), 32'(mRdValid));
`ifdef SD_DIGIT_CHECK_EN
        compare("bad_digit", 32'(bus.o_bad_digit), 32'(mBad));
`endif
    endtask

    // One clock cycle: drive, predict, advance to the next falling edge, check status
    task automatic applyStimulus(input bit st, input bit dv, input logic [DIN_W-1:0] din,
                                 input bit hd, input bit dn, input bit re,
                                 input logic [ADDR_W-1:0] ra, input bit useConst = 1'b0,
                                 input logic [VEC_W-1:0] cp = '0,
                                 input logic [VEC_W-1:0] cm = '0);
        bit               expReady, accept, bad;
        logic [DIN_W-1:0] dc;
        logic [DIN_W-1:0] cand[$];
        rdExp_t           e;
        bus.i_start       = st;
        bus.i_digit_valid = dv;
        bus.i_digit_in    = din;
        bus.i_hold        = hd;
        bus.i_done        = dn;
        bus.i_rd_en       = re;
        bus.i_rd_addr     = ra;
        #1;
        expReady = (mState == M_FILL) && !hd && !mFull;
        compare("ready", 32'(bus.o_ready), 32'(expReady));
        accept = expReady && dv && !st;
        dc = cleanDigit(din, bad);
        if (re) begin
            e.check = 1'b1;
            e.plus  = '0;
            e.minus = '0;
            if (useConst) begin
                e.plus  = cp;
                e.minus = cm;
            end else if (int'(ra) >= DEPTH) begin
                e.plus  = '0;
            end else if ((int'(ra) == mWrWord) && !mFull) begin
                cand = mCur;
                if (accept) cand.push_back(dc);
                packWord(cand, e.plus, e.minus);
            end else if (mMemValid[ra]) begin
                e.plus  = mMemPlus[ra];
                e.minus = mMemMinus[ra];
            end else begin
                e.check = 1'b0;
            end
            expQ.push_back(e);
        end
        mRdValid = re;
        if (st) begin
            mState = M_FILL;
            mWrWord = 0;
            mCnt = 0;
            mFull = 1'b0;
            mOverflow = 1'b0;
            mBad = 1'b0;
            mCur.delete();
        end else begin
            if (mFull && dv) mOverflow = 1'b1;
            if (!hd) begin
                if (mState == M_FILL) begin
                    if (accept) begin
                        mCur.push_back(dc);
                        if (mCnt < (2**CNT_W - 1)) mCnt++;
                        if (bad) mBad = 1'b1;
                        if (mCur.size() == DPW) modelCommit();
                    end
                    if (!mFull && dn) mState = M_FLUSH;
                end else if (mState == M_FLUSH) begin
                    if (mCur.size() > 0) modelCommit();
                    if (!mFull) mState = M_FILL;
                end
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, '0);
    endtask

    // Scoreboard monitor: every presented read is matched against the oldest prediction
    always @(negedge clk) begin
        if (rst_n && bus.o_rd_valid) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL rd_unexpected: rd_valid=1 with no pending read at %0t", $time);
            end else begin
                rdExp_t e;
                e = expQ.pop_front();
                if (e.check) begin
                    compare("rd_plus", 32'(bus.o_rd_plus), 32'(e.plus));
                    compare("rd_minus", 32'(bus.o_rd_minus), 32'(e.minus));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.i_start = 0; bus.i_digit_valid = 0; bus.i_digit_in = '0; bus.i_hold = 0;
        bus.i_done = 0; bus.i_rd_en = 0; bus.i_rd_addr = '0;
        mState = M_IDLE; mWrWord = 0; mCnt = 0; mFull = 0; mOverflow = 0; mBad = 0;
        mRdValid = 0;
        for (int i = 0; i < DEPTH; i++) mMemValid[i] = 1'b0;

        repeat (3) @(negedge clk);
        compare("rst_ready", 32'(bus.o_ready), 32'd0);
        compare("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        compare("rst_rd_plus", 32'(bus.o_rd_plus), 32'd0);
        compare("rst_rd_minus", 32'(bus.o_rd_minus), 32'd0);
        compare("rst_digit_cnt", 32'(bus.o_digit_cnt), 32'd0);
        compare("rst_wr_word", 32'(bus.o_wr_word), 32'd0);
        compare("rst_full", 32'(bus.o_full), 32'd0);
        compare("rst_overflow", 32'(bus.o_overflow), 32'd0);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] four digits on ch0 form word0");
        applyStimulus(1, 0, '0, 0, 0, 0, '0);
        applyStimulus(0, 1, 4'b0010, 0, 0, 0, '0);
        applyStimulus(0, 1, 4'b0001, 0, 0, 0, '0);
        applyStimulus(0, 1, 4'b0000, 0, 0, 0, '0);
        applyStimulus(0, 1, 4'b0010, 0, 0, 0, '0);
        compare("t1_wr_word", 32'(bus.o_wr_word), 32'd1);
        compare("t1_digit_cnt", 32'(bus.o_digit_cnt), 32'd4);
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd0, 1, 8'h09, 8'h04);

        $display("[TB] bypass read of the partial word1");
        applyStimulus(0, 1, 4'b0010, 0, 0, 0, '0);
        applyStimulus(0, 1, 4'b0010, 0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd1, 1, 8'h0C, 8'h00);

        $display("[TB] done flushes the zero-padded word1");
        applyStimulus(0, 0, '0, 0, 1, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, 0, '0);
        compare("t3_wr_word", 32'(bus.o_wr_word), 32'd2);
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd1, 1, 8'h0C, 8'h00);
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd0, 1, 8'h09, 8'h04);

        $display("[TB] hold freezes intake");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'b0110, 1, 0, 0, '0);
        compare("t4_digit_cnt_held", 32'(bus.o_digit_cnt), 32'd6);
        applyStimulus(0, 1, 4'b0110, 0, 0, 0, '0);
        compare("t4_digit_cnt_resume", 32'(bus.o_digit_cnt), 32'd7);
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd9, 1, '0, '0);

        $display("[TB] fill to full, then overflow");
        applyStimulus(1, 0, '0, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH*DPW; i++)
            applyStimulus(0, 1, DIN_W'($urandom_range(0, 15)), 0, 0, 0, '0);
        compare("t5_full", 32'(bus.o_full), 32'd1);
        applyStimulus(0, 1, 4'b1010, 0, 0, 1, 4'd3);
        compare("t5_overflow", 32'(bus.o_overflow), 32'd1);
        applyStimulus(0, 0, '0, 0, 0, 1, ADDR_W'(DEPTH - 1));
        applyStimulus(1, 0, '0, 0, 0, 0, '0);
        compare("t5_full_cleared", 32'(bus.o_full), 32'd0);
        compare("t5_overflow_cleared", 32'(bus.o_overflow), 32'd0);

`ifdef SD_DIGIT_CHECK_EN
        $display("[TB] illegal digit on ch1");
        applyStimulus(0, 1, 4'b1110, 0, 0, 0, '0);
        compare("t6_bad_digit", 32'(bus.o_bad_digit), 32'd1);
        applyStimulus(0, 0, '0, 0, 1, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, 0, '0);
        applyStimulus(0, 0, '0, 0, 0, 1, 4'd0, 1, 8'h08, 8'h00);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 119) == 0), ($urandom_range(0, 9) < 7),
                          DIN_W'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 32) == 0), ($urandom_range(0, 1) == 1),
                          ADDR_W'($urandom_range(0, 15)));
        end
        idle(3);
        compare("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
